// File: rtl/multi_channel_rom_server_pkg.sv
// Shared constants and helpers for the multi-channel ROM server.
// ROM_OUTREG_EN selects the two-stage read pipeline (LAT = 2) instead of one stage.
package rom_server_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel index width; never zero so a single-channel build still has a tag bit.
    function automatic int ch_w(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

`ifdef ROM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

endpackage

// File: rtl/multi_channel_rom_server_if.sv
// Requester-side bus of the ROM server: per-channel requests and addresses in, grant and
// tagged read data out.
interface multi_channel_rom_server_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int CHANNELS   = 4
);
    logic [CHANNELS-1:0]            req;
    logic [CHANNELS*ADDR_WIDTH-1:0] addr;
    logic [CHANNELS-1:0]            gnt;
    logic [CHANNELS-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic                           busy;

    modport master (output req, addr, input gnt, rd_valid, rd_data, busy);
    modport slave  (input req, addr, output gnt, rd_valid, rd_data, busy);
endinterface

// File: rtl/multi_channel_rom_server_rr_arbiter.sv
// Round-robin arbiter: one-hot grant combinational from req and the pointer; the pointer
// moves one past the winner after each grant.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    output logic [CHANNELS-1:0] gnt,
    output logic [CH_W-1:0]     gnt_idx
);
    logic [CH_W-1:0] ptr;
    logic            found;

    // Two passes: channels at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (rst_n && !found && req[j] && (j >= int'(ptr))) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = CH_W'(j);
            end
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (rst_n && !found && req[j] && (j < int'(ptr))) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = CH_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: rtl/multi_channel_rom_server.sv
// Shared lookup ROM serving CHANNELS requesters through one synchronous read port.
// ROM_OUTREG_EN adds an output register after the ROM (latency 2 instead of 1).
module multi_channel_rom_server
    import rom_server_pkg::*;
#(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 12,
    parameter int    CHANNELS   = 4,
    parameter string INIT_FILE  = "wave.hex"
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_channel_rom_server_if.slave   bus
);
    localparam int CH_W = ch_w(CHANNELS);
    typedef logic [CH_W-1:0] ch_idx_t;

    logic [DATA_WIDTH-1:0] rom [2**ADDR_WIDTH];

    logic [CHANNELS-1:0]   gnt;
    ch_idx_t               gnt_idx;
    logic                  take;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [LAT-1:0]        tag_v;
    ch_idx_t               tag_idx [LAT];

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign take     = |gnt;
    assign sel_addr = bus.addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef ROM_OUTREG_EN
    logic [DATA_WIDTH-1:0] rom_q;

    // Left unreset so the read port maps onto a block RAM with registered output.
    always_ff @(posedge clk) begin
        if (take) begin
            rom_q <= rom[sel_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (tag_v[0]) begin
            rd_data <= rom_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (take) begin
            rd_data <= rom[sel_addr];
        end
    end
`endif

    // Owner tag rides alongside the data; clearing it on reset kills in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= take;
            tag_idx[0] <= gnt_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = tag_v[LAT-1] ? (CHANNELS'(1) << tag_idx[LAT-1]) : '0;
    assign bus.busy     = |tag_v;
endmodule

// File: tb/tb_multi_channel_rom_server.sv
// Self-checking bench for multi_channel_rom_server; expected latency follows ROM_OUTREG_EN
// through the package LAT constant.
module tb_multi_channel_rom_server;
    import rom_server_pkg::*;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_channel_rom_server_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH)) bus();

    multi_channel_rom_server #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CHANNELS   (CH),
        .INIT_FILE  ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        int          ch;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] rom_m [2**AW];
    logic [CH-1:0] req_v;
    logic [AW-1:0] addr_a [CH];
    int            p_m, cyc, grant_ch;
    int            n_cmp, n_err;
    logic [DW-1:0] last_m;
    logic [CH-1:0] exp_gnt, exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_busy;

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < CH; i++) bus.addr[i*AW +: AW] = addr_a[i];
    endtask

    // Reference: pending reads keyed by the cycle they must retire in.
    task automatic model_eval();
        @(negedge clk);
        exp_gnt   = '0;
        exp_valid = '0;
        exp_busy  = 1'b0;
        grant_ch  = -1;
        if (!rst_n) begin
            pend.delete();
            p_m    = 0;
            last_m = '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                int j;
                j = (p_m + i) % CH;
                if (grant_ch < 0 && req_v[j]) grant_ch = j;
            end
            if (grant_ch >= 0) exp_gnt[grant_ch] = 1'b1;
            foreach (pend[i]) if (pend[i].due >= cyc && pend[i].due < cyc + LAT) exp_busy = 1'b1;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].due == cyc) begin
                    exp_valid[pend[i].ch] = 1'b1;
                    last_m = pend[i].data;
                    pend.delete(i);
                    break;
                end
            end
        end
        exp_data = last_m;
    endtask

    task automatic model_commit();
        if (rst_n && grant_ch >= 0) begin
            pend.push_back('{due: cyc + LAT, ch: grant_ch, data: rom_m[addr_a[grant_ch]]});
            p_m = (grant_ch + 1) % CH;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int t = 0; t < 6 + LAT; t++) begin
            rst_n = (t >= 3);
            req_v = (t <= 3) ? '1 : '0;
            if (t == 0) for (int i = 0; i < CH; i++) addr_a[i] = AW'($urandom);
            drive();
            model_eval();
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL reset_gnt t=%0d got=%b want=%b", t, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.rd_valid !== exp_valid) begin n_err++; $display("FAIL reset_valid t=%0d got=%b want=%b", t, bus.rd_valid, exp_valid); end
            n_cmp++; if (bus.rd_data !== exp_data) begin n_err++; $display("FAIL reset_data t=%0d got=%h want=%h", t, bus.rd_data, exp_data); end
            n_cmp++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL reset_busy t=%0d got=%b want=%b", t, bus.busy, exp_busy); end
            if (t == 3) begin
                n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt got=%b want=0001", bus.gnt); end
            end
            model_commit();
        end
    endtask

    task automatic test_single_read();
        int gcyc;
        gcyc = -1;
        req_v = 4'b0100;
        addr_a[2] = 12'h010;
        for (int t = 0; t < 12; t++) begin
            drive();
            model_eval();
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL single_gnt t=%0d got=%b want=%b", t, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.rd_valid !== exp_valid) begin n_err++; $display("FAIL single_valid t=%0d got=%b want=%b", t, bus.rd_valid, exp_valid); end
            n_cmp++; if (bus.rd_data !== exp_data) begin n_err++; $display("FAIL single_data t=%0d got=%h want=%h", t, bus.rd_data, exp_data); end
            if (gcyc >= 0 && cyc == gcyc + LAT) begin
                n_cmp++; if (bus.rd_valid !== 4'b0100) begin n_err++; $display("FAIL single_tag got=%b want=0100", bus.rd_valid); end
                n_cmp++; if (bus.rd_data !== 16'hBEEF) begin n_err++; $display("FAIL single_beef got=%h want=beef", bus.rd_data); end
            end
            if (gcyc < 0 && bus.gnt === 4'b0100) gcyc = cyc;
            model_commit();
            if (gcyc >= 0) req_v = '0;
        end
        n_cmp++; if (gcyc < 0) begin n_err++; $display("FAIL single_timeout got=no_grant want=grant"); end
    endtask

    task automatic test_round_robin();
        logic [CH-1:0] exp_rr;
        for (int t = 0; t < 12 + LAT; t++) begin
            rst_n = (t >= 2);
            if (t == 2) begin
                req_v = '1;
                for (int i = 0; i < CH; i++) addr_a[i] = AW'($urandom);
            end else if (t < 2 || t >= 10) begin
                req_v = '0;
            end
            drive();
            model_eval();
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt t=%0d got=%b want=%b", t, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.rd_valid !== exp_valid) begin n_err++; $display("FAIL rr_valid t=%0d got=%b want=%b", t, bus.rd_valid, exp_valid); end
            n_cmp++; if (bus.rd_data !== exp_data) begin n_err++; $display("FAIL rr_data t=%0d got=%h want=%h", t, bus.rd_data, exp_data); end
            n_cmp++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL rr_busy t=%0d got=%b want=%b", t, bus.busy, exp_busy); end
            if (t >= 2 && t < 10) begin
                exp_rr = 4'b0001 << ((t - 2) % 4);
                n_cmp++; if (bus.gnt !== exp_rr) begin n_err++; $display("FAIL rr_order t=%0d got=%b want=%b", t, bus.gnt, exp_rr); end
            end
            model_commit();
            if (grant_ch >= 0) addr_a[grant_ch] = AW'($urandom);
        end
    endtask

    task automatic test_wrap();
        logic [CH-1:0] order [3];
        order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b1000;
        req_v = 4'b1000;
        addr_a[3] = 12'hFFF;
        for (int t = 0; t < 5 + LAT; t++) begin
            drive();
            model_eval();
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL wrap_gnt t=%0d got=%b want=%b", t, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.rd_valid !== exp_valid) begin n_err++; $display("FAIL wrap_valid t=%0d got=%b want=%b", t, bus.rd_valid, exp_valid); end
            n_cmp++; if (bus.rd_data !== exp_data) begin n_err++; $display("FAIL wrap_data t=%0d got=%h want=%h", t, bus.rd_data, exp_data); end
            if (t < 3) begin
                n_cmp++; if (bus.gnt !== order[t]) begin n_err++; $display("FAIL wrap_order t=%0d got=%b want=%b", t, bus.gnt, order[t]); end
            end
            if (t == LAT) begin
                n_cmp++; if (bus.rd_data !== rom_m[4095]) begin n_err++; $display("FAIL wrap_top_addr got=%h want=%h", bus.rd_data, rom_m[4095]); end
            end
            model_commit();
            case (t)
                0: begin req_v = 4'b1001; addr_a[0] = AW'($urandom); addr_a[3] = AW'($urandom); end
                1: req_v = 4'b1000;
                default: req_v = '0;
            endcase
        end
    endtask

    task automatic test_withdrawal();
        req_v = 4'b0011;
        addr_a[0] = AW'($urandom);
        addr_a[1] = AW'($urandom);
        for (int t = 0; t < 4 + LAT; t++) begin
            drive();
            model_eval();
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL wd_gnt t=%0d got=%b want=%b", t, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.rd_valid !== exp_valid) begin n_err++; $display("FAIL wd_valid t=%0d got=%b want=%b", t, bus.rd_valid, exp_valid); end
            n_cmp++; if (bus.gnt[1] !== 1'b0 || bus.rd_valid[1] !== 1'b0) begin
                n_err++; $display("FAIL wd_ch1 t=%0d got=gnt%b/valid%b want=0/0", t, bus.gnt[1], bus.rd_valid[1]);
            end
            model_commit();
            req_v = (t == 0) ? 4'b0001 : '0;
            if (t == 0) addr_a[0] = AW'($urandom);
        end
    endtask

    task automatic test_reset_midflight();
        req_v = '1;
        for (int i = 0; i < CH; i++) addr_a[i] = AW'($urandom);
        for (int t = 0; t < 6 + LAT; t++) begin
            rst_n = (t == 0 || t >= 3);
            drive();
            model_eval();
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL mid_gnt t=%0d got=%b want=%b", t, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.rd_data !== exp_data) begin n_err++; $display("FAIL mid_data t=%0d got=%h want=%h", t, bus.rd_data, exp_data); end
            if (t >= 1) begin
                n_cmp++; if (bus.rd_valid !== '0 || bus.busy !== 1'b0) begin
                    n_err++; $display("FAIL mid_flush t=%0d got=valid%b/busy%b want=0000/0", t, bus.rd_valid, bus.busy);
                end
            end
            model_commit();
            req_v = '0;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 420; t++) begin
            for (int i = 0; i < CH; i++) begin
                if (t >= 400) begin
                    req_v[i] = 1'b0;
                end else if (!req_v[i] && $urandom_range(2) == 0) begin
                    req_v[i]  = 1'b1;
                    addr_a[i] = ($urandom_range(7) == 0) ? '1 : AW'($urandom);
                end else if (req_v[i] && $urandom_range(15) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
            drive();
            model_eval();
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt t=%0d got=%b want=%b", t, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.rd_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid t=%0d got=%b want=%b", t, bus.rd_valid, exp_valid); end
            n_cmp++; if (bus.rd_data !== exp_data) begin n_err++; $display("FAIL rnd_data t=%0d got=%h want=%h", t, bus.rd_data, exp_data); end
            n_cmp++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy t=%0d got=%b want=%b", t, bus.busy, exp_busy); end
            model_commit();
            if (grant_ch >= 0) begin
                if ($urandom_range(1) == 0) req_v[grant_ch] = 1'b0;
                else addr_a[grant_ch] = AW'($urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; p_m = 0; last_m = '0; grant_ch = -1;
        req_v = '0;
        for (int i = 0; i < CH; i++) addr_a[i] = '0;
        drive();
        for (int i = 0; i < 2**AW; i++) rom_m[i] = DW'($urandom);
        rom_m[12'h010] = 16'hBEEF;
        for (int i = 0; i < 2**AW; i++) dut.rom[i] = rom_m[i];
        test_reset();
        test_single_read();
        test_round_robin();
        test_wrap();
        test_withdrawal();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
